// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite subordinate in front of a 2^ADDR_W byte SRAM
// organised as 32-bit little-endian words.
//
// Optional feature macro: AHB_SLV_WAIT_EN
//   defined   - every legal transfer is stretched by WAIT_STATES (1..15)
//               data-phase wait cycles using a 4-bit down-counter.
//   undefined - zero-wait operation; WAIT_STATES is ignored.
//
// Errors (HSIZE=11 or a misaligned halfword/word) always take the two-cycle
// ERROR response and never touch memory.
//
// Reads are issued with the address-phase HADDR into a synchronous RAM read.
// HRDATA is held from the first data cycle. A write commits at the edge
// that ends its last data cycle. A read whose address phase coincides with
// that cycle, to the same word, gets the write lanes merged in.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no data phase, or a zero-wait OKAY data phase
// WAIT  | stretching a legal data phase (AHB_SLV_WAIT_EN only)
// ERR1  | first error cycle: HREADYOUT=0, HRESP=1
// ERR2  | second error cycle: HREADYOUT=1, HRESP=1

module ahb_sram_slave #(
  parameter int ADDR_W      = 15,
  parameter int WAIT_STATES = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [1:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int WA_W  = ADDR_W - 2;
  localparam int WORDS = 1 << WA_W;

`ifdef AHB_SLV_WAIT_EN
  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2, S_WAIT} state_t;
  logic [3:0] wait_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;
`endif

  state_t state;

  logic [31:0] mem [WORDS];

  logic            accept;
  logic            illegal;
  logic            rd_accept;
  logic [WA_W-1:0] a_word;
  logic [3:0]      a_mask;

  logic            dp_valid;
  logic            dp_write;
  logic [WA_W-1:0] dp_word;
  logic [3:0]      dp_mask;
  logic            commit;
  logic [31:0]     merged;

  // Byte lanes touched by a transfer of the given size at byte offset lo.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   lane_mask = 4'b0001 << lo;
      2'b01:   lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  assign accept    = HSEL & HTRANS[1] & HREADY;
  assign a_word    = HADDR[ADDR_W-1:2];
  assign a_mask    = lane_mask(HSIZE, HADDR[1:0]);
  assign rd_accept = accept & ~illegal & ~HWRITE;

  // A write's memory update happens only in its final (ready) data cycle.
  assign commit = dp_valid & dp_write & HREADYOUT;

  // Alignment check on the address-phase size and low address bits.
  always_comb begin
    case (HSIZE)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = HADDR[0];
      2'b10:   illegal = |HADDR[1:0];
      default: illegal = 1'b1;
    endcase
  end

  // Capture the address phase of a legal transfer for its data phase.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_word  <= '0;
      dp_mask  <= '0;
    end else if (HREADY) begin
      dp_valid <= accept & ~illegal;
      dp_write <= HWRITE;
      dp_word  <= a_word;
      dp_mask  <= a_mask;
    end else if (HREADYOUT) begin
      // Bus stalled by another subordinate after our data phase ended.
      dp_valid <= 1'b0;
    end
  end

  // SRAM array write port; contents survive reset.
  always_ff @(posedge Clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_mask[i]) mem[dp_word][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Read word with the committing write's lanes forwarded on a same-word hit.
  always_comb begin
    merged = mem[a_word];
    if (commit && (dp_word == a_word)) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_mask[i]) merged[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  // Synchronous read register; loaded only by an accepted legal read.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      HRDATA <= '0;
    end else if (rd_accept) begin
      HRDATA <= merged;
    end
  end

  // Response FSM with registered HREADYOUT/HRESP.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_ERR2: begin
          if (accept && illegal) begin
            state     <= S_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else if (accept) begin
`ifdef AHB_SLV_WAIT_EN
            state     <= S_WAIT;
            wait_cnt  <= 4'(WAIT_STATES);
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b0;
`else
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
`endif
          end else begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
`ifdef AHB_SLV_WAIT_EN
        S_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            HREADYOUT <= 1'b1;
          end else begin
            wait_cnt  <= wait_cnt - 4'd1;
          end
        end
`endif
        default: begin
          state     <= S_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
        end
      endcase
    end
  end

  // Inputs the protocol defines but this subordinate does not need.
  logic unused_ok;
  assign unused_ok = ^{HMASTLOCK, HTRANS[0], HADDR[31:ADDR_W], 4'(WAIT_STATES)};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: directed scenarios plus a short
// random burst, checked through a scoreboard queue filled at address accept
// and drained when each data phase completes.

module tb_ahb_sram_slave;

  localparam int ADDR_W = 15;
  localparam int WS     = 2;
`ifdef AHB_SLV_WAIT_EN
  localparam int WS_EXP = WS;
`else
  localparam int WS_EXP = 0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [1:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HMASTLOCK;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  ahb_sram_slave #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Rst(Rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  // Single subordinate on the bus: bus ready follows our ready.
  assign HREADY = HREADYOUT;

  always #5 Clk = ~Clk;

  typedef struct {
    logic        is_read;
    logic        is_err;
    logic [31:0] data;
    int          waits;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] model [int];
  int          total = 0;
  int          passed = 0;
  int          low_cnt = 0;
  logic        bus_rdy;

  function automatic bit misaligned(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr[0] == 1'b1;
      2'd2:    return addr[1:0] != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic void model_write(input logic [1:0] size, input logic [31:0] addr,
                                      input logic [31:0] wdata);
    int w;
    logic [31:0] v;
    bit hit;
    w = int'(addr[ADDR_W-1:2]);
    v = model.exists(w) ? model[w] : 32'h0;
    for (int b = 0; b < 4; b++) begin
      hit = (size == 2'd2) ||
            (size == 2'd1 && ((b / 2) == int'(addr[1]))) ||
            (size == 2'd0 && b == int'(addr[1:0]));
      if (hit) v[8*b +: 8] = wdata[8*b +: 8];
    end
    model[w] = v;
  endfunction

  // One clock: check the data phase in flight at the negedge, then advance.
  task automatic tick();
    sb_t it;
    @(negedge Clk);
    bus_rdy = HREADYOUT;
    if (sbq.size() > 0) begin
      if (!HREADYOUT) begin
        low_cnt++;
        total++;
        if (HRESP !== sbq[0].is_err) $display("FAIL stall_resp: got %b expected %b", HRESP, sbq[0].is_err);
        else passed++;
        if (sbq[0].is_read && !sbq[0].is_err) begin
          total++;
          if (HRDATA !== sbq[0].data) $display("FAIL rdata_hold: got %h expected %h", HRDATA, sbq[0].data);
          else passed++;
        end
      end else begin
        it = sbq.pop_front();
        total++;
        if (HRESP !== it.is_err) $display("FAIL resp: got %b expected %b", HRESP, it.is_err);
        else passed++;
        total++;
        if (low_cnt !== it.waits) $display("FAIL wait_cycles: got %0d expected %0d", low_cnt, it.waits);
        else passed++;
        if (it.is_read && !it.is_err) begin
          total++;
          if (HRDATA !== it.data) $display("FAIL rdata: got %h expected %h", HRDATA, it.data);
          else passed++;
        end
        low_cnt = 0;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  // Present an address phase, wait for it to be taken, then start its data phase.
  task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    sb_t it;
    int n;
    bit legal_acc;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus_rdy && n < 64);
    if (!bus_rdy) begin
      total++;
      $display("FAIL accept_timeout: got ready %b expected 1", bus_rdy);
    end
    legal_acc  = sel && trans[1];
    it.is_err  = legal_acc && misaligned(size, addr);
    it.is_read = legal_acc && !wr;
    it.waits   = it.is_err ? 1 : (legal_acc ? WS_EXP : 0);
    it.data    = 32'h0;
    if (legal_acc && !it.is_err && wr) model_write(size, addr, wdata);
    if (it.is_read) it.data = model[int'(addr[ADDR_W-1:2])];
    sbq.push_back(it);
    HWDATA = wdata;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 64) begin
      tick();
      n++;
    end
    if (sbq.size() > 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = 0;
    HWDATA = 0; HMASTLOCK = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    total++; if (HREADYOUT !== 1'b1) $display("FAIL reset_ready: got %b expected 1", HREADYOUT); else passed++;
    total++; if (HRESP !== 1'b0) $display("FAIL reset_resp: got %b expected 0", HRESP); else passed++;
    total++; if (HRDATA !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", HRDATA); else passed++;
    Rst = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_byte_write();
    issue(1, 2'b10, 1, 2'd2, 32'h0000, 32'h11223344);
    issue(1, 2'b10, 1, 2'd0, 32'h0003, 32'hA55A5A5A);
    issue(1, 2'b10, 0, 2'd2, 32'h0000, 32'h0);
    issue(1, 2'b10, 1, 2'd0, 32'h0001, 32'h0000C700);
    issue(1, 2'b10, 0, 2'd2, 32'h0000, 32'h0);
    drain();
  endtask

  task automatic test_back_to_back();
    issue(1, 2'b10, 1, 2'd2, 32'h0100, 32'h12345678);
    issue(1, 2'b10, 1, 2'd1, 32'h0102, 32'hBEEF1111);
    issue(1, 2'b11, 0, 2'd2, 32'h0100, 32'h0);
    issue(1, 2'b10, 1, 2'd0, 32'h0100, 32'h000000EE);
    issue(1, 2'b11, 0, 2'd2, 32'h0100, 32'h0);
    issue(1, 2'b10, 0, 2'd2, 32'h0100, 32'h0);
    drain();
  endtask

  task automatic test_misaligned();
    issue(1, 2'b10, 1, 2'd2, 32'h0002, 32'hFFFFFFFF);
    issue(1, 2'b10, 1, 2'd1, 32'h0001, 32'hFFFFFFFF);
    issue(1, 2'b10, 1, 2'd3, 32'h0000, 32'hFFFFFFFF);
    issue(1, 2'b10, 0, 2'd2, 32'h0101, 32'h0);
    issue(1, 2'b10, 0, 2'd2, 32'h0000, 32'h0);
    drain();
  endtask

  task automatic test_wait_states();
    issue(1, 2'b10, 0, 2'd2, 32'h0100, 32'h0);
    drain();
    issue(1, 2'b10, 1, 2'd2, 32'h0104, 32'h0F0E0D0C);
    issue(1, 2'b10, 0, 2'd2, 32'h0104, 32'h0);
    drain();
  endtask

  task automatic test_idle_deselect();
    issue(1, 2'b00, 1, 2'd2, 32'h0000, 32'hFFFFFFFF);
    issue(1, 2'b01, 1, 2'd2, 32'h0000, 32'hFFFFFFFF);
    issue(0, 2'b10, 1, 2'd2, 32'h0000, 32'hFFFFFFFF);
    issue(1, 2'b10, 0, 2'd2, 32'h0000, 32'h0);
    drain();
  endtask

  task automatic test_reset_mid();
    logic [31:0] old;
    issue(1, 2'b10, 1, 2'd2, 32'h0200, 32'hCAFEF00D);
    drain();
    old = model[32'h200 >> 2];
    issue(1, 2'b10, 1, 2'd2, 32'h0200, 32'hDEADBEEF);
    Rst = 1'b1;
    HSEL = 0; HTRANS = 0;
    #1;
    total++; if (HREADYOUT !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", HREADYOUT); else passed++;
    total++; if (HRESP !== 1'b0) $display("FAIL midrst_resp: got %b expected 0", HRESP); else passed++;
    sbq.delete();
    low_cnt = 0;
    model[32'h200 >> 2] = old;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    issue(1, 2'b10, 0, 2'd2, 32'h0200, 32'h0);
    drain();
  endtask

  task automatic test_random();
    logic [1:0]  size;
    logic [31:0] addr;
    logic        wr;
    for (int w = 0; w < 16; w++) issue(1, 2'b10, 1, 2'd2, 32'h0C00 + 32'(4*w), $urandom);
    for (int k = 0; k < 60; k++) begin
      size = 2'($urandom_range(0, 2));
      addr = 32'h0C00 + 32'(4 * $urandom_range(0, 15));
      if (size == 2'd0) addr[1:0] = 2'($urandom_range(0, 3));
      if (size == 2'd1) addr[1] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) addr[0] = 1'b1;
      if ($urandom_range(0, 9) == 0) size = 2'd3;
      wr = 1'($urandom_range(0, 1));
      issue(1, 2'($urandom_range(2, 3)), wr, size, addr, $urandom);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_back_to_back();
    test_misaligned();
    test_wait_states();
    test_idle_deselect();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
